// File: rtl/psl_eventually_checker.sv
// Bounded-liveness checker for "a0 -> eventually a1" properties.
// Each trigger opens a timestamped obligation; a fulfil or an expiry closes the oldest one.
module psl_eventually_checker #(
    parameter int DEPTH = 4,
    parameter int BOUND = 8,
    parameter int CW    = 8
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic                       en,
    input  logic                       trig,
    input  logic                       ful,
    output logic                       o,
    output logic                       fail,
    output logic                       fail_sticky,
    output logic                       ovf,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] BOUND_W = CW'(BOUND);
    localparam logic [NW-1:0] DEPTH_W = NW'(DEPTH);

    logic [CW-1:0] mem_q [DEPTH];
    logic [CW-1:0] mem_d [DEPTH];
    logic [CW-1:0] now_q, now_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [NW-1:0] count_q, count_d;
    logic          fail_q, fail_d;
    logic          o_q, o_d;
    logic          sticky_q, sticky_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] age;
    logic          has;
    logic          expire;
    logic          pop;
    logic          instant;
    logic          want;
    logic          push;

    // Age of the oldest obligation; wrap-safe because BOUND is below 2**CW.
    assign age     = now_q - mem_q[head_q];
    assign has     = (count_q != '0);
    assign expire  = has && !ful && (age == BOUND_W);
    assign pop     = has && (ful || expire);
    assign instant = trig && ful && !has;
    assign want    = trig && !instant;
    assign push    = want && (pop || (count_q != DEPTH_W));

    // Next-state: at most one pop and one push per enabled edge; disabled edges freeze.
    always_comb begin
        now_d    = now_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        mem_d    = mem_q;
        fail_d   = 1'b0;
        o_d      = 1'b1;
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        if (en) begin
            now_d = now_q + CW'(1);
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push) begin
                mem_d[tail_q] = now_q;
                tail_d        = tail_q + PW'(1);
            end
            count_d  = count_q + NW'(push) - NW'(pop);
            if (want && !push) begin
                ovf_d = 1'b1;
            end
            fail_d   = expire;
            o_d      = !expire;
            sticky_d = sticky_q | expire;
        end
    end

    // State registers with synchronous reset that discards all open obligations.
    always_ff @(posedge clk) begin
        if (r) begin
            mem_q    <= '{default: '0};
            now_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            fail_q   <= 1'b0;
            o_q      <= 1'b1;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            now_q    <= now_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            fail_q   <= fail_d;
            o_q      <= o_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o           = o_q;
    assign fail        = fail_q;
    assign fail_sticky = sticky_q;
    assign ovf         = ovf_q;
    assign pending     = count_q;

endmodule

// File: doc/psl_eventually_checker.md
Name: psl_eventually_checker

Overview:
- Bounded-liveness runtime checker for simulation and emulation of PSL "a0 -> eventually a1" properties.
- Each trigger (antecedent) opens an obligation; an obligation closes when a fulfil (consequent) event arrives within BOUND cycles.
- Sits directly upstream of the assertion sink: its o output drives the sink's i input, replacing the empty PSL_EVENTUALLY/PSL_IMPL placeholders with real sequential checking.

Parameters:
- DEPTH, 4: max outstanding obligations; power of 2, >= 2.
- BOUND, 8: max edges from trigger to fulfil, inclusive; 1 <= BOUND < 2**CW.
- CW, 8: width of the free-running edge counter and of the stored timestamps.

Ports:
- clk  input  1  clock; all state updates on posedge.
- r  input  1  reset; synchronous, active-high.
- en  input  1  checker enable; low freezes all state.
- trig  input  1  antecedent event; opens one obligation.
- ful  input  1  consequent event; closes the oldest open obligation.
- o  output  1  property status to the assertion sink; 1 = holding.
- fail  output  1  one-cycle pulse when an obligation expires.
- fail_sticky  output  1  set on any fail; cleared only by r.
- ovf  output  1  sticky; set when a trigger is dropped because the queue is full.
- pending  output  $clog2(DEPTH+1)  number of open obligations, registered.

Behaviour:
- Reset:
  - Applies when r=1 at a posedge; overrides all other inputs.
  - Queue empty, pending=0, edge counter=0, o=1, fail=0, fail_sticky=0, ovf=0.
  - Reset mid-operation discards all open obligations; they never produce a fail.
- Timing:
  - "Edge k" = the k-th enabled posedge after reset.
  - The edge counter now increments by 1 per enabled edge and wraps mod 2**CW.
  - Storage is a circular FIFO of CW-bit timestamps with head/tail pointers and a count.
- Age:
  - age = (now - head_stamp) mod 2**CW, evaluated before this edge's update.
  - Wrap-safe because BOUND < 2**CW.
- Per enabled edge, evaluate in this order:
  - 1. Expire: if pending>0, head age == BOUND and ful=0, pop the head and flag an expiry.
  - 2. Fulfil: if ful=1 and pending>0, pop the head. ful with an empty queue and trig=0 is ignored.
  - 3. Trigger, empty-queue case: if trig=1 and ful=1 with the queue empty before this edge, the obligation is satisfied immediately. No push.
  - 4. Trigger, otherwise: trig=1 pushes stamp=now if there is space after steps 1-2.
  - 5. Overflow: if no space after steps 1-2, drop the trigger and set ovf.
- Occupancy: at most one pop and one push per edge. Full + pop + trig → count unchanged, ovf not set.
- Expiry rate: stamps are strictly increasing, so at most one obligation can expire per edge.
- Fail timing and outputs:
  - An expiry at edge k gives fail=1, o=0 and fail_sticky=1, all registered and visible after edge k.
  - fail and o return to 0 and 1 after the next edge unless another expiry occurs.
  - o == !fail at all times.
- A trigger at edge k is satisfied by ful at any edge k..k+BOUND. With no ful, it expires at edge k+BOUND.
- en=0:
  - No push or pop; counter and queue frozen; pending, fail_sticky and ovf held.
  - fail forced to 0 and o to 1 after that edge.
  - Ages do not advance while disabled.
- pending is the registered post-update count and never exceeds DEPTH.

Test Plan:
- Reset, en=1, BOUND=8; trig at edge 0, ful at edge 5 → pending=1 after edges 0-4, 0 after edge 5; fail, fail_sticky and ovf stay 0; o stays 1.
- trig at edge 0, no ful → fail=1, o=0 only in the cycle after edge 8; fail_sticky=1 thereafter; pending=0 after edge 8.
- Empty queue, trig and ful together at edge 3 → pending stays 0; no fail ever.
- trig at edges 0-4 (DEPTH=4), no ful → pending=4, ovf=1 after edge 4; fail pulses after edges 8, 9, 10, 11; pending reaches 0 after edge 11.
- Queue full, trig and ful together at one edge → pending stays 4, ovf stays 0; the new obligation expires BOUND edges later.
- pending=3, then r=1 for one edge → pending=0, fail_sticky=0, ovf=0, o=1; no fail during the following 20 edges.
- Separately: en=0 for 10 cycles mid-obligation → the expiry is delayed by exactly 10 cycles.
